wb_write_scheduler: RTL and testbench
=====================================

# wb_write_scheduler

Writeback-port scheduler for the Y86-64 pipeline register file. It takes the W-stage instruction bundle and decodes it into 0, 1 or 2 register write requests. These are queued in a small FIFO and issued one per cycle to a single-write-port register file. When the queue cannot absorb the current instruction, it back-pressures the pipeline through `W_stall`, and it exports a per-register pending-write scoreboard for the hazard unit.

## Interface
- `DEPTH`, 4: write-request FIFO entries, power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `W_valid`  in  1  a valid instruction is present in W this cycle.
- `W_icode`  in  4  W-stage instruction code.
- `W_dstE`  in  4  E destination; 4'hF (RNONE) means no write.
- `W_dstM`  in  4  M destination; 4'hF means no write.
- `W_valE`  in  64  E result.
- `W_valM`  in  64  memory result.
- `W_stall`  out  1  the W bundle is not accepted this cycle; the pipeline holds W.
- `wr_en`  out  1  register-file write strobe.
- `wr_addr`  out  4  register-file write index, 0..14.
- `wr_data`  out  64  register-file write data.
- `q_count`  out  $clog2(DEPTH+1)  occupied FIFO entries.
- `pend_mask`  out  15  bit r = at least one queued write targets register r.

## Operation
- Decode; `need` is the number of requests, ordered first then second:
  - cmovxx (2), irmovq (3), OPq (6): {dstE←valE}.
  - mrmovq (5): {dstM←valM}.
  - call (8), ret (9), pushq (A): {4←valE}.
  - popq (B): {4←valE, then dstM←valM}.
  - All other icodes: none.
- A request whose destination is 4'hF is dropped and does not count in `need`.
- `free = DEPTH − q_count`, from registered state only. A same-cycle pop does not create room.
- `W_stall = W_valid & (need > free)`. A bundle with need = 0 never stalls.
- Accept when `W_valid & ~W_stall`:
  - Push the requests in order: one or two entries at tail, tail+1.
  - Partial acceptance is forbidden.
- Issue:
  - `wr_en = (q_count != 0)`.
  - `wr_addr` and `wr_data` are the head entry, driven combinationally from registered FIFO state.
  - The head pops on every cycle in which `wr_en` = 1. The register file must accept one write per cycle.
- Push and pop in the same cycle: `q_count` next = count + pushed − 1.
- Pointers wrap modulo DEPTH.
- popq with dstM = 4: both entries target r4. The valM entry issues last, so r4 ends with valM (architectural rule).
- Reset:
  - Pointers, `q_count` and all scoreboard counters are cleared.
  - `wr_en`, `wr_addr`, `wr_data`, `q_count`, `pend_mask` and `W_stall` read 0.
  - Queued writes are discarded, including when reset is asserted mid-drain.

## Timing
- An entry accepted at edge N appears on the write port during cycle N+1. The second entry of a pair appears at N+2 at the earliest.
- FIFO latency is 1 cycle plus the occupancy ahead of the entry.
- `W_stall` is combinational from `W_valid`/`W_icode`/`W_dst*` and registered `q_count`. It has no path from `wr_*`.
- `q_count` and `pend_mask` are valid in the cycle after the edge that changes them.
- Throughput is one write per cycle. A stream of popqs (2 requests per instruction) therefore stalls every other cycle once the FIFO saturates.

## Configuration
- `WB_SCOREBOARD_EN` defined:
  - Per-register counters of width $clog2(DEPTH+1), incremented per pushed entry to r and decremented on pop of r.
  - Simultaneous inc/dec of the same r nets to zero change.
  - A double push to the same r (popq dstM = 4) adds 2.
  - `pend_mask[r] = (cnt[r] != 0)`.
- `WB_SCOREBOARD_EN` undefined: no counters are built and `pend_mask` is tied to 0.

## Test plan
1. Reset: hold `rst_n` low 3 cycles → all outputs 0. Release with no `W_valid` → `wr_en` stays 0.
2. irmovq, dstE = 3, valE = 0x1234, at edge N → cycle N+1: `wr_en` = 1, addr 3, data 0x1234, `pend_mask` = 0x0008. Cycle N+2: `wr_en` = 0, `pend_mask` = 0.
3. popq, dstM = 5, valE = 0x100, valM = 0xAB:
   - N+1: addr 4, data 0x100.
   - N+2: addr 5, data 0xAB.
   - With dstM = 4: the final r4 write is 0xAB, and `pend_mask[4]` stays set through N+2.
4. Back-pressure (DEPTH = 4): issue three back-to-back popqs.
   - Counts go 2 → 3.
   - The third sees free = 1 → `W_stall` = 1 for one cycle, then it is accepted.
   - All 6 writes issue in order with no loss or duplication.
5. Drops: OPq with dstE = F and rmmovq (4) with `W_valid` = 1 → no push, `W_stall` = 0, `q_count` unchanged.
6. Assert `rst_n` low mid-drain with `q_count` = 3 → same cycle: `wr_en` = 0, `q_count` = 0, `pend_mask` = 0. No stale writes after release.

Source files
------------

// File: rtl/wb_write_scheduler.sv
// rtl/wb_write_scheduler.sv - Y86-64 writeback-port scheduler with request FIFO
//
// Purpose:
//   Decodes the W-stage bundle into 0, 1 or 2 register-file write requests.
//   The requests are queued in a DEPTH-entry FIFO and issued one per cycle to a
//   single-write-port register file. W_stall back-pressures the pipeline when
//   the whole bundle does not fit. An optional per-register pending-write
//   scoreboard drives pend_mask.
//
// Configuration:
//   WB_SCOREBOARD_EN - when defined, build per-register pending counters;
//                      otherwise pend_mask is tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   W_valid             W bundle present this cycle
//   W_icode             W-stage instruction code
//   W_dstE, W_dstM      destinations (4'hF = no write)
//   W_valE, W_valM      E result, memory result
//   W_stall             bundle not accepted this cycle
//   wr_en/addr/data     register-file write port (head of FIFO)
//   q_count             occupied FIFO entries
//   pend_mask           bit r set while a queued write targets register r

module wb_write_scheduler #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         W_valid,
  input  logic [3:0]                   W_icode,
  input  logic [3:0]                   W_dstE,
  input  logic [3:0]                   W_dstM,
  input  logic [63:0]                  W_valE,
  input  logic [63:0]                  W_valM,
  output logic                         W_stall,
  output logic                         wr_en,
  output logic [3:0]                   wr_addr,
  output logic [63:0]                  wr_data,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic [14:0]                  pend_mask
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [3:0]  RNONE = 4'hF;
  localparam logic [3:0]  RSP   = 4'h4;

  // FIFO state
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    addr_mem [DEPTH];
  logic [63:0]   data_mem [DEPTH];

  // Raw decoded requests (slot 0 = first in program order)
  logic          r0_v, r1_v;
  logic [3:0]    r0_a, r1_a;
  logic [63:0]   r0_d, r1_d;

  // Compacted requests actually pushed
  logic [1:0]    need;
  logic [3:0]    p0_a, p1_a;
  logic [63:0]   p0_d, p1_d;

  logic [CW-1:0] free;
  logic          accept;
  logic [1:0]    push_n;
  logic          pop;
  logic [AW-1:0] tail_p1;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  always_comb begin
    r0_v = 1'b0;
    r0_a = RNONE;
    r0_d = '0;
    r1_v = 1'b0;
    r1_a = RNONE;
    r1_d = '0;
    unique case (W_icode)
      4'h2, 4'h3, 4'h6: begin
        r0_v = (W_dstE != RNONE);
        r0_a = W_dstE;
        r0_d = W_valE;
      end
      4'h5: begin
        r0_v = (W_dstM != RNONE);
        r0_a = W_dstM;
        r0_d = W_valM;
      end
      4'h8, 4'h9, 4'hA: begin
        r0_v = 1'b1;
        r0_a = RSP;
        r0_d = W_valE;
      end
      4'hB: begin
        // Stack-pointer update first so a popq into %rsp leaves valM in r4.
        r0_v = 1'b1;
        r0_a = RSP;
        r0_d = W_valE;
        r1_v = (W_dstM != RNONE);
        r1_a = W_dstM;
        r1_d = W_valM;
      end
      default: begin
        r0_v = 1'b0;
      end
    endcase
  end

  // Squeeze out a dropped first request so pushes are always contiguous.
  always_comb begin
    need = {1'b0, r0_v} + {1'b0, r1_v};
    if (r0_v) begin
      p0_a = r0_a;
      p0_d = r0_d;
      p1_a = r1_a;
      p1_d = r1_d;
    end else begin
      p0_a = r1_a;
      p0_d = r1_d;
      p1_a = RNONE;
      p1_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Admission: free space from registered count only, all-or-nothing
  // ---------------------------------------------------------------------------
  assign free    = CW'(DEPTH) - count_q;
  assign W_stall = W_valid & (int'(need) > int'(free));
  assign accept  = W_valid & ~W_stall;
  assign push_n  = accept ? need : 2'd0;

  // ---------------------------------------------------------------------------
  // Issue port
  // ---------------------------------------------------------------------------
  assign wr_en   = (count_q != '0);
  assign pop     = wr_en;
  assign wr_addr = wr_en ? addr_mem[head_q] : 4'h0;
  assign wr_data = wr_en ? data_mem[head_q] : 64'h0;
  assign q_count = count_q;

  // ---------------------------------------------------------------------------
  // Pointer / count update
  // ---------------------------------------------------------------------------
  assign tail_p1 = tail_q + AW'(1);

  always_comb begin
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(push_n);
    count_d = count_q + CW'(push_n) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through wr_en-gated outputs.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      addr_mem[tail_q] <= p0_a;
      data_mem[tail_q] <= p0_d;
    end
    if (push_n == 2'd2) begin
      addr_mem[tail_p1] <= p1_a;
      data_mem[tail_p1] <= p1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard
  // ---------------------------------------------------------------------------
`ifdef WB_SCOREBOARD_EN
  logic [CW-1:0] cnt_q [15];
  logic [CW-1:0] cnt_d [15];

  // A popq into r4 hits both push slots and adds 2; a same-cycle pop of r
  // cancels one increment.
  always_comb begin
    for (int r = 0; r < 15; r++) begin
      cnt_d[r] = cnt_q[r]
               + CW'((push_n != 2'd0) && (p0_a == 4'(r)))
               + CW'((push_n == 2'd2) && (p1_a == 4'(r)))
               - CW'(pop && (addr_mem[head_q] == 4'(r)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 15; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < 15; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int r = 0; r < 15; r++) pend_mask[r] = (cnt_q[r] != '0);
  end
`else
  assign pend_mask = '0;
`endif

endmodule

// File: tb/tb_wb_write_scheduler.sv
// tb/tb_wb_write_scheduler.sv - directed self-checking bench for wb_write_scheduler

module tb_wb_write_scheduler;

  logic        clk;
  logic        rst_n;
  logic        W_valid;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic        W_stall;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [2:0]  q_count;
  logic [14:0] pend_mask;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0]  log_a [$];
  logic [63:0] log_d [$];

  wb_write_scheduler #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .W_valid  (W_valid),
    .W_icode  (W_icode),
    .W_dstE   (W_dstE),
    .W_dstM   (W_dstM),
    .W_valE   (W_valE),
    .W_valM   (W_valM),
    .W_stall  (W_stall),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .q_count  (q_count),
    .pend_mask(pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] pm(input logic [14:0] m);
`ifdef WB_SCOREBOARD_EN
    return m;
`else
    return 15'h0 & m;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] de,
                       input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    W_valid = v;
    W_icode = ic;
    W_dstE  = de;
    W_dstM  = dm;
    W_valE  = ve;
    W_valM  = vm;
  endtask

  task automatic idle();
    drive(1'b0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
  endtask

  task automatic log_write();
    if (wr_en) begin
      log_a.push_back(wr_addr);
      log_d.push_back(wr_data);
    end
  endtask

  logic [3:0]  exp_a [6];
  logic [63:0] exp_d [6];

  initial begin
    rst_n = 1'b0;
    idle();

    // 1. Reset
    repeat (3) step();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_q_count", q_count, 0);
    check("rst_pend", pend_mask, 0);
    check("rst_stall", W_stall, 0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_wr_en", wr_en, 0);

    // 2. irmovq $0x1234, %rbx
    drive(1'b1, 4'h3, 4'h3, 4'hF, 64'h1234, 64'h0);
    check("irm_stall", W_stall, 0);
    step();
    idle();
    check("irm_wr_en", wr_en, 1);
    check("irm_addr", wr_addr, 4'h3);
    check("irm_data", wr_data, 64'h1234);
    check("irm_count", q_count, 1);
    check("irm_pend", pend_mask, pm(15'h0008));
    step();
    check("irm_done_en", wr_en, 0);
    check("irm_done_pend", pend_mask, 0);
    check("irm_done_count", q_count, 0);

    // 3a. popq %rbp
    drive(1'b1, 4'hB, 4'h4, 4'h5, 64'h100, 64'hAB);
    check("pop5_stall", W_stall, 0);
    step();
    idle();
    check("pop5_n1_addr", wr_addr, 4'h4);
    check("pop5_n1_data", wr_data, 64'h100);
    check("pop5_n1_count", q_count, 2);
    check("pop5_n1_pend", pend_mask, pm(15'h0030));
    step();
    check("pop5_n2_addr", wr_addr, 4'h5);
    check("pop5_n2_data", wr_data, 64'hAB);
    check("pop5_n2_pend", pend_mask, pm(15'h0020));
    step();
    check("pop5_n3_en", wr_en, 0);

    // 3b. popq %rsp: valM must be the last r4 write
    drive(1'b1, 4'hB, 4'h4, 4'h4, 64'h100, 64'hAB);
    step();
    idle();
    check("pop4_n1_addr", wr_addr, 4'h4);
    check("pop4_n1_data", wr_data, 64'h100);
    check("pop4_n1_pend", pend_mask, pm(15'h0010));
    step();
    check("pop4_n2_addr", wr_addr, 4'h4);
    check("pop4_n2_data", wr_data, 64'hAB);
    check("pop4_n2_pend", pend_mask, pm(15'h0010));
    step();
    check("pop4_n3_en", wr_en, 0);
    check("pop4_n3_pend", pend_mask, 0);

    // 4. Back-pressure with three back-to-back popqs
    exp_a[0] = 4'h4; exp_d[0] = 64'hA0;
    exp_a[1] = 4'h1; exp_d[1] = 64'hA1;
    exp_a[2] = 4'h4; exp_d[2] = 64'hB0;
    exp_a[3] = 4'h2; exp_d[3] = 64'hB1;
    exp_a[4] = 4'h4; exp_d[4] = 64'hC0;
    exp_a[5] = 4'h3; exp_d[5] = 64'hC1;
    drive(1'b1, 4'hB, 4'h4, 4'h1, 64'hA0, 64'hA1);
    check("bp_a_stall", W_stall, 0);
    step();
    check("bp_a_count", q_count, 2);
    log_write();
    drive(1'b1, 4'hB, 4'h4, 4'h2, 64'hB0, 64'hB1);
    check("bp_b_stall", W_stall, 0);
    step();
    check("bp_b_count", q_count, 3);
    log_write();
    drive(1'b1, 4'hB, 4'h4, 4'h3, 64'hC0, 64'hC1);
    check("bp_c_stall1", W_stall, 1);
    step();
    check("bp_c_count1", q_count, 2);
    log_write();
    check("bp_c_stall2", W_stall, 0);
    step();
    idle();
    check("bp_c_count2", q_count, 3);
    log_write();
    repeat (4) begin
      step();
      log_write();
    end
    check("bp_nwrites", log_a.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < log_a.size()) begin
        check($sformatf("bp_addr%0d", i), log_a[i], exp_a[i]);
        check($sformatf("bp_data%0d", i), log_d[i], exp_d[i]);
      end
    end
    check("bp_empty", wr_en, 0);

    // 5. Dropped requests
    drive(1'b1, 4'h6, 4'hF, 4'hF, 64'h55, 64'h0);
    check("drop_opq_stall", W_stall, 0);
    step();
    check("drop_opq_count", q_count, 0);
    check("drop_opq_en", wr_en, 0);
    drive(1'b1, 4'h4, 4'h2, 4'hF, 64'h66, 64'h77);
    check("drop_rm_stall", W_stall, 0);
    step();
    idle();
    check("drop_rm_count", q_count, 0);
    check("drop_rm_en", wr_en, 0);

    // 6. Reset mid-drain
    drive(1'b1, 4'hB, 4'h4, 4'h1, 64'h11, 64'h12);
    step();
    drive(1'b1, 4'hB, 4'h4, 4'h2, 64'h21, 64'h22);
    step();
    idle();
    check("mid_count", q_count, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", wr_en, 0);
    check("mid_rst_count", q_count, 0);
    check("mid_rst_pend", pend_mask, 0);
    check("mid_rst_addr", wr_addr, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst_en%0d", i), wr_en, 0);
    end

    // Queue still usable after the flush
    drive(1'b1, 4'h2, 4'h7, 4'hF, 64'h77, 64'h0);
    step();
    idle();
    check("post_addr", wr_addr, 4'h7);
    check("post_data", wr_data, 64'h77);
    check("post_pend", pend_mask, pm(15'h0080));
    step();
    check("post_done", wr_en, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
